// File: rtl/alu_pkg.sv
// alu_pkg: opcodes and flag bit positions shared by the ALU and its write-back stage
package alu_pkg;
    localparam logic [3:0] ADD       = 4'd1;
    localparam logic [3:0] ADD_CARRY = 4'd2;
    localparam logic [3:0] SUB       = 4'd3;
    localparam logic [3:0] INC       = 4'd4;
    localparam logic [3:0] DEC       = 4'd5;
    localparam logic [3:0] AND       = 4'd6;
    localparam logic [3:0] NOT       = 4'd7;
    localparam logic [3:0] ROL       = 4'd8;
    localparam logic [3:0] ROR       = 4'd9;
    localparam int FLG_PARITY  = 0;
    localparam int FLG_ZERO    = 1;
    localparam int FLG_COUT    = 2;
    localparam int FLG_BORROW  = 3;
    localparam int FLG_INVALID = 4;
endpackage

// File: rtl/alu_wb_stage_if.sv
// alu_wb_stage_if: ALU-result input handshake and consumer output handshake of the write-back stage
interface alu_wb_stage_if #(parameter int B_W = 8);
    logic           in_valid;
    logic           in_ready;
    logic [3:0]     in_opcode;
    logic [B_W-1:0] in_y;
    logic           in_c_out;
    logic           in_borrow;
    logic           in_invalid_op;
    logic           in_zero;
    logic           in_parity;
    logic           out_valid;
    logic           out_ready;
    logic [B_W-1:0] out_y;
    logic [4:0]     out_flags;
    logic [3:0]     out_opcode;
    modport slave (
        input  in_valid, in_opcode, in_y, in_c_out, in_borrow, in_invalid_op, in_zero, in_parity, out_ready,
        output in_ready, out_valid, out_y, out_flags, out_opcode
    );
    modport master (
        output in_valid, in_opcode, in_y, in_c_out, in_borrow, in_invalid_op, in_zero, in_parity, out_ready,
        input  in_ready, out_valid, out_y, out_flags, out_opcode
    );
endinterface

// File: rtl/alu_wb_fifo.sv
// alu_wb_fifo: DEPTH x W in-order synchronous FIFO with occupancy count, full and empty
module alu_wb_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_en_i,
    input  logic [W-1:0] wr_data_i,
    input  logic         rd_en_i,
    output logic [W-1:0] rd_data_o,
    output logic         full_o,
    output logic         empty_o
);
    localparam int PW = $clog2(DEPTH);
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PW:0]   count_q, count_d;
    logic [W-1:0]  mem_q [DEPTH];
    logic          push, pop;
    assign full_o    = count_q == (PW+1)'(DEPTH);
    assign empty_o   = count_q == '0;
    assign push      = wr_en_i && !full_o;
    assign pop       = rd_en_i && !empty_o;
    assign rd_data_o = mem_q[rd_ptr_q];
    // pointers wrap naturally at DEPTH; count only moves when exactly one side transfers
    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d  = (push && !pop) ? count_q + (PW+1)'(1) : (pop && !push) ? count_q - (PW+1)'(1) : count_q;
    end
    // pointer, count and storage registers; reset also clears storage so the head reads 0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (push) mem_q[wr_ptr_q] <= wr_data_i;
        end
    end
endmodule

// File: rtl/alu_wb_stage.sv
// alu_wb_stage: queues ALU results for the consumer and keeps the carry flag fed back to the ALU;
// the invalid-op counter exists only when ALU_WB_ERRCNT_EN is defined, otherwise err_count is 0
module alu_wb_stage
    import alu_pkg::*;
#(
    parameter int B_W   = 8,
    parameter int DEPTH = 2,
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    alu_wb_stage_if.slave    bus,
    input  logic             clear_carry,
    output logic             carry_flag,
    output logic [ERR_W-1:0] err_count
);
    localparam int W = 4 + B_W + 5;
    logic         push, full, empty;
    logic [4:0]   in_flags;
    logic [W-1:0] rd_data;
    logic         carry_q, carry_d;
    assign push           = bus.in_valid && bus.in_ready;
    assign bus.in_ready   = !full;
    assign bus.out_valid  = !empty;
    assign carry_flag     = carry_q;
    assign {bus.out_opcode, bus.out_y, bus.out_flags} = rd_data;
    alu_wb_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (bus.in_valid),
        .wr_data_i ({bus.in_opcode, bus.in_y, in_flags}),
        .rd_en_i   (bus.out_ready),
        .rd_data_o (rd_data),
        .full_o    (full),
        .empty_o   (empty)
    );
    // pack ALU flags into their fixed bit positions and pick the next carry; clear always wins
    always_comb begin
        in_flags              = '0;
        in_flags[FLG_PARITY]  = bus.in_parity;
        in_flags[FLG_ZERO]    = bus.in_zero;
        in_flags[FLG_COUT]    = bus.in_c_out;
        in_flags[FLG_BORROW]  = bus.in_borrow;
        in_flags[FLG_INVALID] = bus.in_invalid_op;
        carry_d = clear_carry ? 1'b0 :
                  (!push || bus.in_invalid_op) ? carry_q :
                  (bus.in_opcode == ADD_CARRY || bus.in_opcode == INC) ? bus.in_c_out :
                  (bus.in_opcode == SUB || bus.in_opcode == DEC) ? bus.in_borrow : carry_q;
    end
    // architectural carry/borrow flag register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) carry_q <= 1'b0;
        else carry_q <= carry_d;
    end
`ifdef ALU_WB_ERRCNT_EN
    logic [ERR_W-1:0] err_q, err_d;
    // saturating count of accepted invalid-opcode results
    always_comb err_d = (push && bus.in_invalid_op && err_q != '1) ? err_q + ERR_W'(1) : err_q;
    // invalid-op counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) err_q <= '0;
        else err_q <= err_d;
    end
    assign err_count = err_q;
`else
    assign err_count = '0;
`endif
endmodule
